// File: rtl/uart_ctrl_pkg.sv
// Shared constants for the UART host register block: register map, FSM encoding
// and the reset values of the RX interrupt holdoff counters.
package uart_ctrl_pkg;

   localparam logic [3:0] ADDR_DATA     = 4'h0;
   localparam logic [3:0] ADDR_STATUS   = 4'h1;
   localparam logic [3:0] ADDR_CTRL     = 4'h2;
   localparam logic [3:0] ADDR_BAUD     = 4'h3;
   localparam logic [3:0] ADDR_HOLDOFF  = 4'h4;
   localparam logic [3:0] ADDR_INT_EN   = 4'h5;
   localparam logic [3:0] ADDR_INT_PEND = 4'h6;

   localparam logic [10:0] HOLDOFF_TIME_RST = 11'd16;
   localparam logic [10:0] HOLDOFF_CNT_RST  = 11'd8;

   // Returned by a DATA read while the RX FIFO is empty.
   localparam logic [31:0] RDATA_EMPTY = 32'h8000_0000;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACK     = 2'd1,
      ST_RX_POP  = 2'd2,
      ST_RX_WAIT = 2'd3
   } state_t;

endpackage

// File: rtl/uart_irq_ctrl.sv
// Interrupt pending/enable logic: rising-edge capture of int_status into sticky
// pending bits, write-1-to-clear (a same-cycle set wins), registered irq.
module uart_irq_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] int_status,
   input  logic [4:0] int_en,
   input  logic [4:0] int_clr,
   output logic [4:0] int_pend,
   output logic       irq
);

   logic [4:0] status_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         status_d <= '0;
         int_pend <= '0;
         irq      <= 1'b0;
      end else begin
         status_d <= int_status;
         int_pend <= (int_pend & ~int_clr) | (int_status & ~status_d);
         irq      <= |(int_pend & int_en);
      end
   end

endmodule

// File: rtl/uart_host_ctrl.sv
// UART host-side register block and bus FSM. Optional TX overflow guard is
// enabled by defining UART_HOST_CTRL_OVF_GUARD_EN.
//
// state      | meaning
// ST_IDLE    | waiting for bus_req; decodes and performs non-popping accesses
// ST_ACK     | bus_ack and bus_rdata are valid for this single cycle
// ST_RX_POP  | rx_byte_host_rd strobe is high
// ST_RX_WAIT | waiting for rx_byte_host_dv to capture the popped byte
module uart_host_ctrl
   import uart_ctrl_pkg::*;
#(
   parameter int FIFO_DEPTH = 1024,
   parameter int BAUD_RST   = 868,
   parameter int OVS_RST    = 174
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bus_req,
   input  logic        bus_we,
   input  logic [3:0]  bus_addr,
   input  logic [31:0] bus_wdata,
   output logic        bus_ack,
   output logic [31:0] bus_rdata,
   output logic        tx_en,
   output logic        rx_en,
   output logic [12:0] baud_clk_cnt,
   output logic [9:0]  over_sample_clk_cnt,
   output logic [10:0] rx_int_holdoff_byte_time_cnt,
   output logic [10:0] rx_int_holdoff_byte_cnt,
   output logic [7:0]  tx_byte_host,
   output logic        tx_byte_host_dv,
   input  logic [7:0]  rx_byte_host,
   input  logic        rx_byte_host_dv,
   output logic        rx_byte_host_rd,
   input  logic [10:0] tx_byte_count,
   input  logic [10:0] rx_byte_count,
   input  logic [4:0]  int_status,
   output logic        irq
);

   localparam logic [10:0] FULL_CNT  = 11'(FIFO_DEPTH);
   localparam logic [12:0] BAUD_INIT = 13'(BAUD_RST);
   localparam logic [9:0]  OVS_INIT  = 10'(OVS_RST);

   state_t      state;
   logic        ovf;
   logic        hit;
   logic [4:0]  int_en;
   logic [4:0]  int_clr;
   logic [4:0]  int_pend;
   logic [31:0] rd_mux;
   logic        unused_bits;

   always_comb begin
      hit     = (state == ST_IDLE) && bus_req;
      int_clr = (hit && bus_we && (bus_addr == ADDR_INT_PEND)) ? bus_wdata[4:0] : 5'd0;
      rd_mux  = '0;
      case (bus_addr)
         ADDR_DATA:     rd_mux = RDATA_EMPTY;
         ADDR_STATUS:   rd_mux = {ovf, 4'd0, rx_byte_count, tx_byte_count, int_status};
         ADDR_CTRL:     rd_mux = {30'd0, rx_en, tx_en};
         ADDR_BAUD:     rd_mux = {6'd0, over_sample_clk_cnt, 3'd0, baud_clk_cnt};
         ADDR_HOLDOFF:  rd_mux = {5'd0, rx_int_holdoff_byte_cnt, 5'd0, rx_int_holdoff_byte_time_cnt};
         ADDR_INT_EN:   rd_mux = {27'd0, int_en};
         ADDR_INT_PEND: rd_mux = {27'd0, int_pend};
         default:       rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state                        <= ST_IDLE;
         bus_ack                      <= 1'b0;
         bus_rdata                    <= '0;
         tx_byte_host                 <= '0;
         tx_byte_host_dv              <= 1'b0;
         rx_byte_host_rd              <= 1'b0;
         tx_en                        <= 1'b0;
         rx_en                        <= 1'b0;
         baud_clk_cnt                 <= BAUD_INIT;
         over_sample_clk_cnt          <= OVS_INIT;
         rx_int_holdoff_byte_time_cnt <= HOLDOFF_TIME_RST;
         rx_int_holdoff_byte_cnt      <= HOLDOFF_CNT_RST;
         int_en                       <= '0;
`ifdef UART_HOST_CTRL_OVF_GUARD_EN
         ovf                          <= 1'b0;
`endif
      end else begin
         bus_ack         <= 1'b0;
         bus_rdata       <= '0;
         tx_byte_host_dv <= 1'b0;
         rx_byte_host_rd <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus_req) begin
                  if (!bus_we && (bus_addr == ADDR_DATA) && (rx_byte_count != 11'd0)) begin
                     state           <= ST_RX_POP;
                     rx_byte_host_rd <= 1'b1;
                  end else begin
                     state     <= ST_ACK;
                     bus_ack   <= 1'b1;
                     bus_rdata <= bus_we ? 32'd0 : rd_mux;
                     if (bus_we) begin
                        case (bus_addr)
                           ADDR_DATA: begin
`ifdef UART_HOST_CTRL_OVF_GUARD_EN
                              if (tx_byte_count == FULL_CNT) begin
                                 ovf <= 1'b1;
                              end else begin
                                 tx_byte_host    <= bus_wdata[7:0];
                                 tx_byte_host_dv <= 1'b1;
                              end
`else
                              tx_byte_host    <= bus_wdata[7:0];
                              tx_byte_host_dv <= 1'b1;
`endif
                           end
                           ADDR_CTRL: begin
                              tx_en <= bus_wdata[0];
                              rx_en <= bus_wdata[1];
`ifdef UART_HOST_CTRL_OVF_GUARD_EN
                              if (bus_wdata[31]) ovf <= 1'b0;
`endif
                           end
                           ADDR_BAUD: begin
                              baud_clk_cnt        <= bus_wdata[12:0];
                              over_sample_clk_cnt <= bus_wdata[25:16];
                           end
                           ADDR_HOLDOFF: begin
                              rx_int_holdoff_byte_time_cnt <= bus_wdata[10:0];
                              rx_int_holdoff_byte_cnt      <= bus_wdata[26:16];
                           end
                           ADDR_INT_EN: int_en <= bus_wdata[4:0];
                           default: ;
                        endcase
                     end
                  end
               end
            end
            ST_RX_POP: state <= ST_RX_WAIT;
            ST_RX_WAIT: begin
               if (rx_byte_host_dv) begin
                  state     <= ST_ACK;
                  bus_ack   <= 1'b1;
                  bus_rdata <= {24'd0, rx_byte_host};
               end
            end
            ST_ACK:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef UART_HOST_CTRL_OVF_GUARD_EN
   assign unused_bits = ^bus_wdata[30:27];
`else
   assign ovf         = 1'b0;
   assign unused_bits = ^{bus_wdata[31:27], FULL_CNT};
`endif

   uart_irq_ctrl u_irq (
      .clk        (clk),
      .rst        (rst),
      .int_status (int_status),
      .int_en     (int_en),
      .int_clr    (int_clr),
      .int_pend   (int_pend),
      .irq        (irq)
   );

endmodule

// File: tb/tb_uart_host_ctrl.sv
// Self-checking bench for uart_host_ctrl: directed scenarios plus randomized
// register traffic against a register-level model of the block.
module tb_uart_host_ctrl;

`ifdef UART_HOST_CTRL_OVF_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        bus_req = 1'b0;
   logic        bus_we = 1'b0;
   logic [3:0]  bus_addr = '0;
   logic [31:0] bus_wdata = '0;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic        tx_en, rx_en;
   logic [12:0] baud_clk_cnt;
   logic [9:0]  over_sample_clk_cnt;
   logic [10:0] rx_int_holdoff_byte_time_cnt, rx_int_holdoff_byte_cnt;
   logic [7:0]  tx_byte_host;
   logic        tx_byte_host_dv;
   logic [7:0]  rx_byte_host = '0;
   logic        rx_byte_host_dv = 1'b0;
   logic        rx_byte_host_rd;
   logic [10:0] tx_byte_count = '0;
   logic [10:0] rx_byte_count = '0;
   logic [4:0]  int_status = '0;
   logic        irq;

   uart_host_ctrl dut (
      .clk                          (clk),
      .rst                          (rst),
      .bus_req                      (bus_req),
      .bus_we                       (bus_we),
      .bus_addr                     (bus_addr),
      .bus_wdata                    (bus_wdata),
      .bus_ack                      (bus_ack),
      .bus_rdata                    (bus_rdata),
      .tx_en                        (tx_en),
      .rx_en                        (rx_en),
      .baud_clk_cnt                 (baud_clk_cnt),
      .over_sample_clk_cnt          (over_sample_clk_cnt),
      .rx_int_holdoff_byte_time_cnt (rx_int_holdoff_byte_time_cnt),
      .rx_int_holdoff_byte_cnt      (rx_int_holdoff_byte_cnt),
      .tx_byte_host                 (tx_byte_host),
      .tx_byte_host_dv              (tx_byte_host_dv),
      .rx_byte_host                 (rx_byte_host),
      .rx_byte_host_dv              (rx_byte_host_dv),
      .rx_byte_host_rd              (rx_byte_host_rd),
      .tx_byte_count                (tx_byte_count),
      .rx_byte_count                (rx_byte_count),
      .int_status                   (int_status),
      .irq                          (irq)
   );

   initial forever #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // RX FIFO model and strobe monitors
   logic [7:0] rx_q[$];
   int         tx_pulses = 0;
   int         rd_pulses = 0;
   logic [7:0] last_tx = '0;

   initial forever begin
      @(negedge clk);
      if (tx_byte_host_dv) begin
         tx_pulses++;
         last_tx = tx_byte_host;
      end
      if (rx_byte_host_rd) rd_pulses++;
   end

   // Byte comes back with dv in the cycle after the rd strobe.
   initial forever begin
      @(negedge clk);
      if (rx_byte_host_rd) begin
         @(posedge clk);
         #1;
         rx_byte_host    = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
         rx_byte_count   = 11'(rx_q.size());
         rx_byte_host_dv = 1'b1;
         @(posedge clk);
         #1;
         rx_byte_host_dv = 1'b0;
      end
   end

   // Register-level model
   logic        m_tx_en, m_rx_en, m_ovf;
   logic [12:0] m_baud;
   logic [9:0]  m_ovs;
   logic [10:0] m_ho_time, m_ho_cnt;
   logic [4:0]  m_en, m_pend;

   task automatic model_reset();
      m_tx_en = 0; m_rx_en = 0; m_ovf = 0;
      m_baud = 13'd868; m_ovs = 10'd174;
      m_ho_time = 11'd16; m_ho_cnt = 11'd8;
      m_en = '0; m_pend = '0;
   endtask

   function automatic logic [31:0] model_read(input logic [3:0] a);
      case (a)
         4'h1:    return {m_ovf, 4'd0, rx_byte_count, tx_byte_count, int_status};
         4'h2:    return {30'd0, m_rx_en, m_tx_en};
         4'h3:    return 32'(m_ovs) * 32'd65536 + 32'(m_baud);
         4'h4:    return 32'(m_ho_cnt) * 32'd65536 + 32'(m_ho_time);
         4'h5:    return 32'(m_en);
         4'h6:    return 32'(m_pend);
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_write(input logic [3:0] a, input logic [31:0] wd);
      case (a)
         4'h0: if (GUARD && tx_byte_count == 11'd1024) m_ovf = 1'b1;
         4'h2: begin
            m_tx_en = wd[0];
            m_rx_en = wd[1];
            if (GUARD && wd[31]) m_ovf = 1'b0;
         end
         4'h3: begin m_baud = wd[12:0]; m_ovs = wd[25:16]; end
         4'h4: begin m_ho_time = wd[10:0]; m_ho_cnt = wd[26:16]; end
         4'h5: m_en = wd[4:0];
         4'h6: m_pend = m_pend & ~wd[4:0];
         default: ;
      endcase
   endtask

   task automatic check_outputs(input string tag);
      chk_val({tag, "_tx_en"}, 32'(tx_en), 32'(m_tx_en));
      chk_val({tag, "_rx_en"}, 32'(rx_en), 32'(m_rx_en));
      chk_val({tag, "_baud"}, 32'(baud_clk_cnt), 32'(m_baud));
      chk_val({tag, "_ovs"}, 32'(over_sample_clk_cnt), 32'(m_ovs));
      chk_val({tag, "_ho_time"}, 32'(rx_int_holdoff_byte_time_cnt), 32'(m_ho_time));
      chk_val({tag, "_ho_cnt"}, 32'(rx_int_holdoff_byte_cnt), 32'(m_ho_cnt));
      chk_val({tag, "_irq"}, 32'(irq), 32'(|(m_pend & m_en)));
   endtask

   // One bus access; lat counts negedges from req until ack is seen.
   task automatic bus_xfer(input logic we, input logic [3:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output int lat, output logic leak);
      logic got;
      got  = 1'b0;
      leak = 1'b0;
      lat  = 0;
      rd   = '0;
      @(negedge clk);
      bus_req = 1'b1; bus_we = we; bus_addr = a; bus_wdata = wd;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         lat++;
         if (bus_ack) begin
            got = 1'b1;
            rd  = bus_rdata;
         end else if (bus_rdata != 32'd0) begin
            leak = 1'b1;
         end
      end
      if (!got) chk_val("ack_timeout", 32'd0, 32'd1);
      bus_req = 1'b0; bus_we = 1'b0;
      #1;
   endtask

   logic [31:0] rdat, wd, exp_rd;
   logic [3:0]  addr;
   logic        we, leak, ack_seen;
   int          lat, exp_lat, tx0, rd0, exp_tx, exp_pop;

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk); #1;
      chk_val("rst_ack", 32'(bus_ack), 32'd0);
      chk_val("rst_rdata", bus_rdata, 32'd0);
      chk_val("rst_tx_dv", 32'(tx_byte_host_dv), 32'd0);
      chk_val("rst_rd", 32'(rx_byte_host_rd), 32'd0);
      check_outputs("rst");

      bus_xfer(1'b0, 4'h3, 32'd0, rdat, lat, leak);
      chk_val("rst_baud_rd", rdat, 32'h00AE_0364);
      bus_xfer(1'b0, 4'h2, 32'd0, rdat, lat, leak);
      chk_val("rst_ctrl_rd", rdat, 32'd0);

      // DATA write
      tx0 = tx_pulses;
      bus_xfer(1'b1, 4'h0, 32'h0000_0055, rdat, lat, leak);
      @(negedge clk); #1;
      chk_val("wr_lat", 32'(lat), 32'd1);
      chk_val("wr_pulses", 32'(tx_pulses - tx0), 32'd1);
      chk_val("wr_byte", 32'(last_tx), 32'h55);

      // DATA read with one byte available
      rx_q.push_back(8'hA3);
      rx_byte_count = 11'd1;
      rd0 = rd_pulses;
      bus_xfer(1'b0, 4'h0, 32'd0, rdat, lat, leak);
      chk_val("rd_data", rdat, 32'h0000_00A3);
      chk_val("rd_lat", 32'(lat), 32'd3);
      chk_val("rd_pulses", 32'(rd_pulses - rd0), 32'd1);
      chk_val("rd_leak", 32'(leak), 32'd0);

      // DATA read while empty
      rd0 = rd_pulses;
      bus_xfer(1'b0, 4'h0, 32'd0, rdat, lat, leak);
      @(negedge clk); #1;
      chk_val("empty_data", rdat, 32'h8000_0000);
      chk_val("empty_pulses", 32'(rd_pulses - rd0), 32'd0);
      chk_val("empty_lat", 32'(lat), 32'd1);

      // Interrupts
      bus_xfer(1'b1, 4'h5, 32'h0000_0004, rdat, lat, leak);
      model_write(4'h5, 32'h4);
      int_status = 5'h04;
      m_pend = m_pend | 5'h04;
      repeat (2) @(negedge clk);
      #1;
      chk_val("int_irq_set", 32'(irq), 32'd1);
      bus_xfer(1'b0, 4'h6, 32'd0, rdat, lat, leak);
      chk_val("int_pend_rd", rdat, 32'h4);
      int_status = 5'h00;
      repeat (2) @(negedge clk);
      fork
         bus_xfer(1'b1, 4'h6, 32'h0000_0004, rdat, lat, leak);
         begin
            @(negedge clk);
            int_status = 5'h04;
         end
      join
      bus_xfer(1'b0, 4'h6, 32'd0, rdat, lat, leak);
      chk_val("w1c_set_wins", rdat, 32'h4);
      chk_val("w1c_set_irq", 32'(irq), 32'd1);
      int_status = 5'h00;
      repeat (2) @(negedge clk);
      bus_xfer(1'b1, 4'h6, 32'h0000_0004, rdat, lat, leak);
      model_write(4'h6, 32'h4);
      bus_xfer(1'b0, 4'h6, 32'd0, rdat, lat, leak);
      chk_val("w1c_clear", rdat, 32'h0);
      @(negedge clk); #1;
      chk_val("w1c_irq_low", 32'(irq), 32'd0);

      // Static interrupt sources for the random phase
      int_status = 5'h1B;
      m_pend = m_pend | 5'h1B;
      repeat (2) @(negedge clk);
      #1;

      for (int it = 0; it < 80; it++) begin
         addr = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) addr = 4'h0;
         we = 1'($urandom_range(0, 1));
         wd = $urandom;
         tx_byte_count = 11'($urandom_range(0, 1023));
         if (addr == 4'h0 && !we && $urandom_range(0, 1) == 1) begin
            rx_q.push_back(8'($urandom));
            rx_byte_count = 11'(rx_q.size());
         end
         if (addr == 4'h0) exp_rd = (rx_q.size() != 0) ? {24'd0, rx_q[0]} : 32'h8000_0000;
         else              exp_rd = model_read(addr);
         exp_pop = (!we && addr == 4'h0 && rx_q.size() != 0) ? 1 : 0;
         exp_lat = (exp_pop != 0) ? 3 : 1;
         exp_tx  = (we && addr == 4'h0 && !(GUARD && tx_byte_count == 11'd1024)) ? 1 : 0;
         tx0 = tx_pulses;
         rd0 = rd_pulses;
         bus_xfer(we, addr, wd, rdat, lat, leak);
         if (we) model_write(addr, wd);
         @(negedge clk); #1;
         if (!we) chk_val($sformatf("rnd_rd_a%0d", addr), rdat, exp_rd);
         chk_val("rnd_lat", 32'(lat), 32'(exp_lat));
         chk_val("rnd_leak", 32'(leak), 32'd0);
         chk_val("rnd_tx_pulses", 32'(tx_pulses - tx0), 32'(exp_tx));
         chk_val("rnd_rd_pulses", 32'(rd_pulses - rd0), 32'(exp_pop));
         if (exp_tx != 0) chk_val("rnd_tx_byte", 32'(last_tx), 32'(wd[7:0]));
         check_outputs("rnd");
      end

      // TX FIFO at full depth
      tx_byte_count = 11'd1024;
      tx0 = tx_pulses;
      bus_xfer(1'b1, 4'h0, 32'h0000_003C, rdat, lat, leak);
      model_write(4'h0, 32'h3C);
      @(negedge clk); #1;
      chk_val("full_pulses", 32'(tx_pulses - tx0), GUARD ? 32'd0 : 32'd1);
      bus_xfer(1'b0, 4'h1, 32'd0, rdat, lat, leak);
      chk_val("full_ovf", 32'(rdat[31]), GUARD ? 32'd1 : 32'd0);
      chk_val("full_status", rdat, model_read(4'h1));
      bus_xfer(1'b1, 4'h2, 32'h8000_0000, rdat, lat, leak);
      model_write(4'h2, 32'h8000_0000);
      bus_xfer(1'b0, 4'h1, 32'd0, rdat, lat, leak);
      chk_val("ovf_clear", 32'(rdat[31]), 32'd0);
      tx_byte_count = 11'd0;

      // Reset in the middle of a popping DATA read
      rx_q.delete();
      rx_q.push_back(8'h11);
      rx_byte_count = 11'd1;
      bus_xfer(1'b1, 4'h3, 32'h0123_0456, rdat, lat, leak);
      rd0 = rd_pulses;
      ack_seen = 1'b0;
      @(negedge clk);
      bus_req = 1'b1; bus_we = 1'b0; bus_addr = 4'h0;
      @(negedge clk);
      rst = 1'b1;
      bus_req = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus_ack) ack_seen = 1'b1;
      end
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (bus_ack) ack_seen = 1'b1;
      end
      #1;
      chk_val("mid_rst_ack", 32'(ack_seen), 32'd0);
      chk_val("mid_rst_rd_pulses", 32'(rd_pulses - rd0), 32'd1);
      model_reset();
      check_outputs("mid_rst");
      bus_xfer(1'b0, 4'h3, 32'd0, rdat, lat, leak);
      chk_val("mid_rst_baud_rd", rdat, 32'h00AE_0364);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/uart_host_ctrl.md
UART_HOST_CTRL -- requirements
Module: uart_host_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 1024, depth of each UART FIFO.
REQ-002 SHALL have parameter BAUD_RST, default 868, reset value of baud_clk_cnt.
REQ-003 SHALL have parameter OVS_RST, default 174, reset value of over_sample_clk_cnt.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have bus ports: bus_req in 1, bus_we in 1, bus_addr in 4, bus_wdata in 32, bus_ack out 1, bus_rdata out 32.
REQ-007 SHALL have config outputs: tx_en 1, rx_en 1, baud_clk_cnt 13, over_sample_clk_cnt 10, rx_int_holdoff_byte_time_cnt 11, rx_int_holdoff_byte_cnt 11.
REQ-008 SHALL have FIFO ports: tx_byte_host out 8, tx_byte_host_dv out 1, rx_byte_host in 8, rx_byte_host_dv in 1, rx_byte_host_rd out 1.
REQ-009 SHALL have status inputs tx_byte_count 11, rx_byte_count 11, int_status 5, and output irq 1.

Function
REQ-010 SHALL decode the register map:
- 0x0 DATA: write pushes wdata[7:0] to TX; read pops RX.
- 0x1 STATUS (RO): {ovf[31], rx_byte_count[26:16], tx_byte_count[15:5], int_status[4:0]}.
- 0x2 CTRL: tx_en[0], rx_en[1].
- 0x3 BAUD: baud_clk_cnt[12:0], over_sample_clk_cnt[25:16].
- 0x4 HOLDOFF: byte_time[10:0], byte_cnt[26:16].
- 0x5 INT_EN[4:0].
- 0x6 INT_PEND[4:0], write-1-to-clear.
- Others: read 0, writes ignored.
REQ-011 SHALL run FSM IDLE, ACK, RX_POP, RX_WAIT, accepting bus_req only in IDLE; the master holds req until ack.
REQ-012 In IDLE with req, the FSM SHALL go to ACK for every access except a DATA read with rx_byte_count!=0, which goes to RX_POP.
REQ-013 ACK SHALL assert bus_ack for exactly one cycle, with bus_rdata valid that cycle, then return to IDLE.
REQ-014 RX_POP SHALL pulse rx_byte_host_rd for one cycle, then move to RX_WAIT.
REQ-015 RX_WAIT SHALL capture rx_byte_host into rdata[7:0] when rx_byte_host_dv=1, then move to ACK; DATA-read latency is 3 cycles from req.
REQ-016 A DATA read with rx_byte_count==0 SHALL not pop, and SHALL return rdata=0x8000_0000 (bit31=empty).
REQ-017 A DATA write SHALL pulse tx_byte_host_dv for one cycle, registering tx_byte_host in the same cycle the FSM enters ACK.
REQ-018 INT_PEND[i] SHALL set on a 0->1 transition of int_status[i], detected with a one-cycle delayed copy.
REQ-019 When a set and a W1C hit the same INT_PEND bit in the same cycle, set SHALL win.
REQ-020 irq SHALL be registered |(INT_PEND & INT_EN), one cycle after pending changes.
REQ-021 bus_rdata SHALL be 0 whenever bus_ack=0.

Reset
REQ-022 On rst the block SHALL drive:
- FSM to IDLE; bus_ack, irq, tx_byte_host_dv, rx_byte_host_rd, tx_en, rx_en, INT_EN, INT_PEND, ovf = 0.
- baud_clk_cnt=BAUD_RST, over_sample_clk_cnt=OVS_RST, byte_time=16, byte_cnt=8.
REQ-023 A rst mid-transaction SHALL abandon it with no ack and no further FIFO strobe.

Configuration
REQ-024 With UART_HOST_CTRL_OVF_GUARD_EN defined, a DATA write when tx_byte_count==FIFO_DEPTH SHALL be acked but not pushed, and SHALL set sticky ovf; writing CTRL bit31=1 clears ovf.
REQ-025 Without the macro, DATA writes SHALL always push, and ovf SHALL read 0.

Structure
REQ-026 Package uart_ctrl_pkg SHALL hold the register address constants, FSM state encoding and holdoff reset defaults.
REQ-027 Edge detect, pending, W1C and irq logic SHALL be the sub-module uart_irq_ctrl.

Verification
REQ-028 The bench SHALL cover these scenarios:
- Reset, read BAUD -> 0x00AE_0364; CTRL reads 0.
- Write DATA 0x55 -> single tx_byte_host_dv pulse, tx_byte_host=0x55; ack at cycle 2.
- rx_byte_count=1, DATA read, model returns 0xA3 with dv the cycle after rd -> rdata=0x0000_00A3; ack 3 cycles after req; exactly one rd pulse.
- DATA read with rx_byte_count=0 -> rdata=0x8000_0000; no rd pulse.
- INT_EN=0x04; int_status[2] rises -> INT_PEND=0x04 and irq=1; W1C 0x04 in the same cycle as a new rise -> pend stays 1.
- Macro defined, tx_byte_count=1024, write DATA -> no dv pulse, STATUS[31]=1; CTRL write 0x8000_0000 clears it.
